// File: rtl/ncc_pkg.sv
// Shared types and default geometry for the NCC load controller and its raster counter.
package ncc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_DESC = 2'd1,
      ST_LOAD_WIN  = 2'd2,
      ST_CORR      = 2'd3
   } ncc_ctrl_state_t;

   localparam int NCC_DESC_PIXELS = 256;
   localparam int NCC_WIN_ROWS    = 16;
   localparam int NCC_WIN_COLS    = 80;

   // Counter width that never collapses to zero bits for degenerate sizes.
   function automatic int ncc_cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ncc_raster_counter.sv
// Row/column raster counter: col runs 0..COLS-1, then wraps and advances row.
module ncc_raster_counter
   import ncc_pkg::*;
#(
   parameter int ROWS = NCC_WIN_ROWS,
   parameter int COLS = NCC_WIN_COLS,
   parameter int RW   = ncc_cw(ROWS),
   parameter int CW   = ncc_cw(COLS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [RW-1:0] row_r;
   logic [CW-1:0] col_r;
   logic          col_end_s;
   logic          row_end_s;

   // End-of-line / end-of-frame decode.
   always_comb begin
      col_end_s = (col_r == CW'(COLS - 1));
      row_end_s = (row_r == RW'(ROWS - 1));
      last      = col_end_s && row_end_s;
      row       = row_r;
      col       = col_r;
   end

   // Raster position; clear dominates enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r <= '0;
         col_r <= '0;
      end else if (clr) begin
         row_r <= '0;
         col_r <= '0;
      end else if (en) begin
         if (col_end_s) begin
            col_r <= '0;
            row_r <= row_end_s ? '0 : row_r + RW'(1);
         end else begin
            col_r <= col_r + CW'(1);
         end
      end else begin
         row_r <= row_r;
         col_r <= col_r;
      end
   end

endmodule

// File: rtl/ncc_load_ctrl.sv
// NCC load sequencer: descriptor bytes, then window BRAMs in raster order, then correlation handoff.
// Optional NCC_CTRL_KEEP_DESC_EN adds keepDesc to reuse a previously loaded descriptor.
module ncc_load_ctrl
   import ncc_pkg::*;
#(
   parameter int DESC_PIXELS = NCC_DESC_PIXELS,
   parameter int WIN_ROWS    = NCC_WIN_ROWS,
   parameter int WIN_COLS    = NCC_WIN_COLS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
`ifdef NCC_CTRL_KEEP_DESC_EN
   input  logic                        keepDesc,
`endif
   input  logic [7:0]                  pciIn,
   input  logic                        pciValid,
   output logic                        pciReady,
   output logic                        descShift,
   output logic [WIN_ROWS-1:0]         winWrite,
   output logic [$clog2(WIN_COLS)-1:0] winAddr,
   output logic [7:0]                  winData,
   output logic                        corrStart,
   input  logic                        corrDone,
   output logic                        busy,
   output logic                        done
);

   localparam int DW = ncc_cw(DESC_PIXELS);
   localparam int RW = ncc_cw(WIN_ROWS);
   localparam int CW = $clog2(WIN_COLS);

   ncc_ctrl_state_t state_r;
   logic [DW-1:0]   desc_count_r;
   logic            corr_start_r;
   logic            done_r;
   logic            busy_r;
   logic [RW-1:0]   row_s;
   logic [CW-1:0]   col_s;
   logic            win_last_s;
   logic            in_desc_s;
   logic            in_win_s;
   logic            accept_s;
   logic            win_en_s;
   logic            win_clr_s;
   logic            skip_desc_s;
`ifdef NCC_CTRL_KEEP_DESC_EN
   logic            desc_valid_r;
`endif

   // Byte-path steering; abort masks ready and every strobe in the same cycle.
   always_comb begin
      in_desc_s = (state_r == ST_LOAD_DESC) && !abort;
      in_win_s  = (state_r == ST_LOAD_WIN) && !abort;
      pciReady  = in_desc_s || in_win_s;
      accept_s  = pciValid && pciReady;
      descShift = in_desc_s && pciValid;
      winWrite  = '0;
      if (in_win_s && pciValid) begin
         winWrite[row_s] = 1'b1;
      end else begin
         winWrite = '0;
      end
      winAddr   = in_win_s ? col_s : '0;
      winData   = in_win_s ? pciIn : 8'd0;
      win_en_s  = accept_s && in_win_s;
      win_clr_s = abort || (state_r == ST_IDLE);
   end

   // Descriptor reuse decision for the next start.
   always_comb begin
`ifdef NCC_CTRL_KEEP_DESC_EN
      skip_desc_s = keepDesc && desc_valid_r;
`else
      skip_desc_s = 1'b0;
`endif
   end

   ncc_raster_counter #(
      .ROWS (WIN_ROWS),
      .COLS (WIN_COLS),
      .RW   (RW),
      .CW   (CW)
   ) u_raster (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (win_clr_s),
      .en    (win_en_s),
      .row   (row_s),
      .col   (col_s),
      .last  (win_last_s)
   );

   // Job sequencer with registered corrStart/done/busy; abort overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         desc_count_r <= '0;
         corr_start_r <= 1'b0;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
`ifdef NCC_CTRL_KEEP_DESC_EN
         desc_valid_r <= 1'b0;
`endif
      end else begin
         corr_start_r <= 1'b0;
         done_r       <= 1'b0;
         if (abort) begin
            state_r      <= ST_IDLE;
            desc_count_r <= '0;
            busy_r       <= 1'b0;
`ifdef NCC_CTRL_KEEP_DESC_EN
            if (state_r == ST_LOAD_DESC) begin
               desc_valid_r <= 1'b0;
            end else begin
               desc_valid_r <= desc_valid_r;
            end
`endif
         end else begin
            case (state_r)
               ST_IDLE: begin
                  desc_count_r <= '0;
                  if (start) begin
                     state_r <= skip_desc_s ? ST_LOAD_WIN : ST_LOAD_DESC;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end
               ST_LOAD_DESC: begin
                  if (accept_s) begin
                     desc_count_r <= desc_count_r + DW'(1);
                     if (desc_count_r == DW'(DESC_PIXELS - 1)) begin
                        state_r <= ST_LOAD_WIN;
`ifdef NCC_CTRL_KEEP_DESC_EN
                        desc_valid_r <= 1'b1;
`endif
                     end else begin
                        state_r <= ST_LOAD_DESC;
                     end
                  end else begin
                     desc_count_r <= desc_count_r;
                  end
               end
               ST_LOAD_WIN: begin
                  if (accept_s && win_last_s) begin
                     state_r      <= ST_CORR;
                     corr_start_r <= 1'b1;
                  end else begin
                     state_r <= ST_LOAD_WIN;
                  end
               end
               ST_CORR: begin
                  // corrDone alongside the launch pulse belongs to a stale job.
                  if (corrDone && !corr_start_r) begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_CORR;
                  end
               end
               default: begin
                  state_r      <= ST_IDLE;
                  desc_count_r <= '0;
                  busy_r       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign corrStart = corr_start_r;
   assign done      = done_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_ncc_load_ctrl.sv
// Scoreboard bench for ncc_load_ctrl: a byte-index model predicts every strobe/pulse and its cycle.
module tb_ncc_load_ctrl;

   localparam int DESC = 256;
   localparam int ROWS = 16;
   localparam int COLS = 80;
   localparam int TOTAL = DESC + ROWS * COLS;
   localparam int EV_DESC = 1, EV_WIN = 2, EV_CS = 3, EV_DONE = 4;
`ifdef NCC_CTRL_KEEP_DESC_EN
   localparam bit KEEP_EN = 1'b1;
`else
   localparam bit KEEP_EN = 1'b0;
`endif

   typedef struct {
      int kind;
      int row;
      int col;
      int data;
      int stamp;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              keep_desc = 1'b0;
   logic [7:0]        pciIn = 8'd0;
   logic              pciValid = 1'b0;
   logic              pciReady;
   logic              descShift;
   logic [ROWS-1:0]   winWrite;
   logic [6:0]        winAddr;
   logic [7:0]        winData;
   logic              corrStart;
   logic              corrDone = 1'b0;
   logic              busy;
   logic              done;

   int  n_cmp = 0;
   int  n_fail = 0;
   int  cyc = 0;
   bit  mon_en = 1'b0;
   bit  exp_ready = 1'b0;
   bit  exp_busy = 1'b0;
   ev_t exp_q[$];

   // model: phase 0 idle, 1 descriptor, 2 window, 3 correlation
   int  m_ph = 0;
   int  m_idx = 0;
   bit  m_first = 1'b0;
   bit  m_dvalid = 1'b0;

   ncc_load_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
`ifdef NCC_CTRL_KEEP_DESC_EN
      .keepDesc  (keep_desc),
`endif
      .pciIn     (pciIn),
      .pciValid  (pciValid),
      .pciReady  (pciReady),
      .descShift (descShift),
      .winWrite  (winWrite),
      .winAddr   (winAddr),
      .winData   (winData),
      .corrStart (corrStart),
      .corrDone  (corrDone),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic match(input int kind, input int row, input int col, input int data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d row %0d col %0d, expected none (cycle %0d)",
                  kind, row, col, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_cycle", cyc, e.stamp);
         if (e.kind == EV_WIN) begin
            chk("win_row", row, e.row);
            chk("win_col", col, e.col);
            chk("win_data", data, e.data);
         end else if (e.kind == EV_DESC) begin
            chk("desc_data", data, e.data);
         end
      end
   endtask

   // Monitor: decode DUT activity mid-cycle and reconcile it with the scoreboard.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         chk("pciReady", int'(pciReady), int'(exp_ready));
         chk("busy", int'(busy), int'(exp_busy));
         if (descShift) match(EV_DESC, 0, 0, int'(pciIn));
         if (winWrite != '0) begin
            chk("win_onehot", int'($onehot(winWrite)), 1);
            for (int r = 0; r < ROWS; r++) begin
               if (winWrite[r]) match(EV_WIN, r, int'(winAddr), int'(winData));
            end
         end
         if (corrStart) match(EV_CS, 0, 0, 0);
         if (done) match(EV_DONE, 0, 0, 0);
      end
   end

   task automatic push(input int kind, input int row, input int col, input int data, input int stamp);
      ev_t e;
      e.kind = kind; e.row = row; e.col = col; e.data = data; e.stamp = stamp;
      exp_q.push_back(e);
   endtask

   // One cycle of stimulus; the model predicts this cycle's outputs and the next phase.
   task automatic step(input bit v, input logic [7:0] d, input bit st, input bit ab,
                       input bit cd, input bit kp);
      bit acc;
      pciValid = v; pciIn = d; start = st; abort = ab; corrDone = cd; keep_desc = kp;
      exp_ready = !ab && (m_ph == 1 || m_ph == 2);
      exp_busy  = (m_ph != 0);
      acc = v && exp_ready;
      if (acc && m_ph == 1) push(EV_DESC, 0, 0, int'(d), cyc);
      if (acc && m_ph == 2) push(EV_WIN, (m_idx - DESC) / COLS, (m_idx - DESC) % COLS, int'(d), cyc);
      if (ab) begin
         if (m_ph == 1) m_dvalid = 1'b0;
         m_ph = 0; m_idx = 0;
      end else begin
         case (m_ph)
            0: if (st) begin
                  if (KEEP_EN && keep_desc && m_dvalid) begin
                     m_ph = 2; m_idx = DESC;
                  end else begin
                     m_ph = 1; m_idx = 0;
                  end
               end
            1: if (acc) begin
                  m_idx++;
                  if (m_idx == DESC) begin m_ph = 2; m_dvalid = 1'b1; end
               end
            2: if (acc) begin
                  m_idx++;
                  if (m_idx == TOTAL) begin
                     m_ph = 3; m_first = 1'b1; push(EV_CS, 0, 0, 0, cyc + 1);
                  end
               end
            3: if (m_first) m_first = 1'b0;
               else if (cd) begin m_ph = 0; m_idx = 0; push(EV_DONE, 0, 0, 0, cyc + 1); end
            default: m_ph = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int bubble, input bit pat, input int abort_idx,
                          input int halt_idx, input bit kp, input int corr_delay);
      int guard = 0;
      bit v;
      bit ab;
      logic [7:0] d;
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, kp);
      while ((m_ph == 1 || m_ph == 2) && guard < 8000) begin
         if (halt_idx >= 0 && m_idx >= halt_idx) return;
         v  = ($urandom_range(99) >= bubble);
         d  = pat ? 8'(m_idx) : 8'($urandom);
         ab = (abort_idx >= 0 && m_idx == abort_idx && v);
         step(v, d, 1'($urandom_range(1)), ab, 1'($urandom_range(1)), kp);
         guard++;
      end
      if (guard >= 8000) chk("load_timeout", guard, 0);
      if (m_ph == 3) begin
         step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, kp);
         repeat (corr_delay - 2) step(1'b0, 8'($urandom), 1'($urandom_range(1)), 1'b0, 1'b0, kp);
         step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, kp);
         step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, kp);
      end else begin
         step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, kp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pciValid = 1'b0; start = 1'b0; abort = 1'b0; corrDone = 1'b0; pciIn = 8'd0;
      #1;
      chk("rst_ctrl", int'({pciReady, descShift, corrStart, busy, done}), 0);
      chk("rst_winWrite", int'(winWrite), 0);
      chk("rst_addr_data", int'({winAddr, winData}), 0);
      exp_q.delete();
      m_ph = 0; m_idx = 0; m_first = 1'b0; m_dvalid = 1'b0;
      exp_ready = 1'b0; exp_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      mon_en = 1'b1;
      step(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_job(0, 1'b1, -1, -1, 1'b0, 5);
      run_job(50, 1'b0, -1, -1, 1'b0, 7);
      run_job(10, 1'b0, DESC + 7 * COLS + 40, -1, 1'b0, 5);
      run_job(20, 1'b0, -1, -1, 1'b0, 4);
      run_job(0, 1'b0, 100, -1, 1'b0, 5);
      run_job(30, 1'b0, -1, DESC + 3 * COLS + 11, 1'b0, 5);
      do_reset();
      run_job(0, 1'b0, -1, -1, 1'b1, 5);
      run_job(25, 1'b1, -1, -1, 1'b1, 6);
      repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ncc_load_ctrl.md
# ncc_load_ctrl

Sequencer for the NCC matching engine. It accepts the PCI byte stream and steers bytes into two destinations: first the descriptor shift register, then the 16 per-row window BRAMs in raster order. It then hands off to the correlation datapath and waits for it to finish. It sits between the PCI byte interface and the `ncc` datapath, and is the sole owner of the descriptor shift enable and the window BRAM write ports.

## Interface
Parameters:
- `DESC_PIXELS`, 256: descriptor bytes per load.
- `WIN_ROWS`, 16: window rows, one BRAM per row.
- `WIN_COLS`, 80: pixels per window row (BRAM depth used).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request a new load/compute job; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; highest priority.
- `pciIn`  in  8  byte from PCI.
- `pciValid`  in  1  `pciIn` valid.
- `pciReady`  out  1  controller accepts byte this cycle.
- `descShift`  out  1  shift `pciIn` into the descriptor register.
- `winWrite`  out  WIN_ROWS  one-hot BRAM port-A write enable.
- `winAddr`  out  $clog2(WIN_COLS)  BRAM column address.
- `winData`  out  8  BRAM write data.
- `corrStart`  out  1  one-cycle pulse launching correlation.
- `corrDone`  in  1  correlation finished.
- `busy`  out  1  high in any state but IDLE.
- `done`  out  1  one-cycle pulse on job completion.

## Operation
- States: IDLE, LOAD_DESC, LOAD_WIN, CORR.
- **IDLE**
  - `start` moves to LOAD_DESC.
  - `descCount`, `row` and `col` are cleared on entry.
- **Accepts.** An accept is `pciValid && pciReady`.
- **`pciReady`** is combinational: it is 1 in LOAD_DESC and LOAD_WIN, else 0.
- **LOAD_DESC**
  - `descShift = pciValid`.
  - Each accept increments `descCount`.
  - The accept with `descCount == DESC_PIXELS-1` moves to LOAD_WIN.
- **LOAD_WIN**
  - `winWrite[row] = pciValid`.
  - `winAddr = col`.
  - `winData = pciIn`.
  - Each accept increments `col`. At `col == WIN_COLS-1`, `col` wraps to 0 and `row` increments.
  - The accept at `row == WIN_ROWS-1, col == WIN_COLS-1` moves to CORR.
- **CORR**
  - `corrStart` is high in the first CORR cycle only.
  - `corrDone` is ignored in that cycle.
  - `corrDone` in a later CORR cycle moves to IDLE and pulses `done` in the same transition.
- **Idle byte gaps.** `pciValid` low stalls the counters, and all write strobes are 0.
- **Ignored inputs.**
  - `start` outside IDLE is ignored.
  - `corrDone` outside CORR is ignored.
- **`abort`** from any state goes to IDLE next cycle. It clears the counters, suppresses `done` and `corrStart`, and drops `pciReady`/strobes that same cycle.
- **Simultaneous events.**
  - `abort` with `start` in IDLE: stay IDLE.
  - `abort` on the last byte of a phase: IDLE wins.
- **Reset mid-job** returns to IDLE immediately. No partial-job state survives.

## Timing
- **Reset values:** state IDLE, counters 0, and all outputs 0 (`pciReady`, `descShift`, `winWrite`, `winAddr`, `winData`, `corrStart`, `busy`, `done`).
- **`start` at edge t:** `busy` and `pciReady` go high in cycle t+1.
- **Combinational outputs:** `pciReady`, `descShift`, `winWrite`, `winAddr`, `winData`.
- **Registered outputs:** `corrStart`, `done`, `busy`.
- **Minimum job latency** with continuous valid: DESC_PIXELS + WIN_ROWS·WIN_COLS = 1536 accepts. `corrStart` follows in the cycle after the final window accept.
- **`done`:** rises in the cycle after `corrDone` is sampled. `busy` falls in the same cycle.

## Configuration
- **`NCC_CTRL_KEEP_DESC_EN` defined:**
  - Adds input `keepDesc` (1 bit) and an internal `descValid` flag.
  - `descValid` is set at LOAD_DESC completion. It is cleared by reset and by `abort` during LOAD_DESC.
  - `start && keepDesc && descValid` in IDLE goes directly to LOAD_WIN, skipping the descriptor.
- **Not defined:** no `keepDesc` port, and every job loads the descriptor.

## Structure
- **Package `ncc_pkg`:**
  - state enum `ncc_ctrl_state_t`.
  - default constants `NCC_DESC_PIXELS`, `NCC_WIN_ROWS`, `NCC_WIN_COLS`.
- **Sub-module `ncc_raster_counter`:**
  - Parameterized row/col counter with enable and clear.
  - Outputs `row`, `col` and `last` (final pixel).
  - Used for the window phase.
- The descriptor counter is a plain counter inside the controller.

## Test plan
- **Reset:** `rst_n` low mid-LOAD_WIN → all outputs 0 and state IDLE. After release, `start` begins at LOAD_DESC with `descCount` 0.
- **Full job, continuous valid:** `start`, then 1536 bytes (value = index mod 256), then `corrDone` 5 cycles after `corrStart` → check:
  - 256 `descShift` pulses.
  - Window bytes written in raster order: row 0 gets `winAddr` 0–79 first, `winWrite` one-hot 0x0001; row 15 is last, `winWrite` = 0x8000.
  - `corrStart` one cycle after the 1536th accept.
  - `done` once.
- **Bubbles:** random `pciValid` gaps (50%) → identical write sequence, no strobes during gaps, job completes.
- **Abort in LOAD_WIN at row 7 col 40** → IDLE next cycle, no `corrStart`/`done`. A new `start` reloads from descriptor byte 0.
- **Ignored inputs:** `corrDone` in IDLE/LOAD_DESC, `start` during CORR, and `corrDone` coincident with `corrStart` → no state change. A later `corrDone` completes the job.
- **`NCC_CTRL_KEEP_DESC_EN`:** second job with `keepDesc`=1 → zero `descShift`, first accept writes window row 0 col 0. With `keepDesc`=1 right after reset → descriptor loaded normally.
